// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with preset editing, run/pause control and expiry flags.
// Drives a seven-segment front end with BCD digits, a blanking mask and status levels/pulses.
module bcd_countdown_timer #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter bit WRAP     = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_mode,
    input  logic                inc,
    input  logic                dec,
    input  logic                sel_left,
    input  logic                sel_right,
    input  logic                start,
    output logic [4*DIGITS-1:0] digits,
    output logic [DIGITS-1:0]   cursor,
    output logic [DIGITS-1:0]   mask,
    output logic                running,
    output logic                expired,
    output logic                done
);

    localparam int             PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_SET, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] preset_q, preset_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [DIGITS-1:0]   cursor_q, cursor_d;
    logic                expired_q, expired_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic                running_q, running_d;
    logic                done_q, done_d;

    logic [4*DIGITS-1:0] preset_edit;
    logic [4*DIGITS-1:0] count_dec;
    logic [DIGITS-1:0]   cursor_left, cursor_right;
    logic [DIGITS-1:0]   lead_nz;
    logic [4*DIGITS-1:0] shown_d;
    logic                tick, dec_zero, count_nz;
    logic                inc_only, dec_only;

    assign inc_only = inc & ~dec;
    assign dec_only = dec & ~inc;

    // Per-digit preset edit; only the digit under the cursor changes, no carry between digits.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_edit
        logic [3:0] d, up, dn;
        assign d  = preset_q[4*gi +: 4];
        assign up = (d == 4'd9) ? (WRAP ? 4'd0 : 4'd9) : d + 4'd1;
        assign dn = (d == 4'd0) ? (WRAP ? 4'd9 : 4'd0) : d - 4'd1;
        assign preset_edit[4*gi +: 4] = (cursor_q[gi] && inc_only) ? up :
                                        (cursor_q[gi] && dec_only) ? dn : d;
    end

    always_comb begin : cursor_rotate
        cursor_left  = '0;
        cursor_right = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cursor_left[(i + 1) % DIGITS] = cursor_q[i];
            cursor_right[i]               = cursor_q[(i + 1) % DIGITS];
        end
    end

    always_comb begin : bcd_decrement
        logic borrow;
        count_dec = count_q;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign count_nz = |count_q;
    assign tick     = (state_q == S_RUN) && (presc_q == TICK_LAST);
    assign dec_zero = (count_dec == '0);

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            state_q   <= S_IDLE;
            preset_q  <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            cursor_q  <= DIGITS'(1);
            expired_q <= 1'b0;
            digits_q  <= '0;
            mask_q    <= DIGITS'(1);
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            cursor_q  <= cursor_d;
            expired_q <= expired_d;
            digits_q  <= digits_d;
            mask_q    <= mask_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        preset_d  = preset_q;
        count_d   = count_q;
        presc_d   = presc_q;
        cursor_d  = cursor_q;
        expired_d = 1'b0;
        if (set_mode) begin
            // Entering SET from elsewhere freezes everything; edits start once SET is established.
            state_d = S_SET;
            if (state_q == S_SET) begin
                preset_d = preset_edit;
                if (sel_left && !sel_right) begin
                    cursor_d = cursor_left;
                end else if (sel_right && !sel_left) begin
                    cursor_d = cursor_right;
                end
            end
        end else begin
            unique case (state_q)
                S_SET: begin
                    state_d = S_IDLE;
                    count_d = preset_q;
                    presc_d = '0;
                end
                S_IDLE: begin
                    if (start && count_nz) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        count_d = count_dec;
                    end
                    if (tick && dec_zero) begin
                        state_d   = S_DONE;
                        expired_d = 1'b1;
                    end else if (start) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d = S_IDLE;
                        count_d = preset_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        shown_d   = (state_d == S_SET) ? preset_d : count_d;
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
        digits_d  = shown_d;
        lead_nz   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lead_nz[i] = (|shown_d[4*i +: 4]) | ((i < DIGITS - 1) ? lead_nz[(i + 1) % DIGITS] : 1'b0);
        end
        mask_d = (state_d == S_SET) ? '1 : (lead_nz | DIGITS'(1));
    end

    assign digits  = digits_q;
    assign cursor  = cursor_q;
    assign mask    = mask_q;
    assign running = running_q;
    assign expired = expired_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (2 digits, 4-cycle tick), with a saturating and a wrapping instance.
module tb_bcd_countdown_timer;

    localparam logic [4:0] B_INC = 5'b00001;
    localparam logic [4:0] B_DEC = 5'b00010;
    localparam logic [4:0] B_SL  = 5'b00100;
    localparam logic [4:0] B_SR  = 5'b01000;
    localparam logic [4:0] B_ST  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_mode = 1'b0;
    logic [4:0] btn = '0;

    logic [7:0] digits, w_digits;
    logic [1:0] cursor, mask, w_cursor, w_mask;
    logic       running, expired, done, w_running, w_expired, w_done;
    logic [14:0] obs;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .set_mode(set_mode),
        .inc(btn[0]), .dec(btn[1]), .sel_left(btn[2]), .sel_right(btn[3]), .start(btn[4]),
        .digits(digits), .cursor(cursor), .mask(mask),
        .running(running), .expired(expired), .done(done)
    );

    bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .set_mode(set_mode),
        .inc(btn[0]), .dec(btn[1]), .sel_left(btn[2]), .sel_right(btn[3]), .start(btn[4]),
        .digits(w_digits), .cursor(w_cursor), .mask(w_mask),
        .running(w_running), .expired(w_expired), .done(w_done)
    );

    assign obs = {digits, mask, cursor, running, expired, done};

    typedef struct packed {
        logic        setm;
        logic [4:0]  btn;
        logic [7:0]  extra;
        logic [14:0] v;
        logic        chk_w;
        logic [7:0]  w;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Expected observation: {digits, mask, cursor, running, expired, done}
    function automatic logic [14:0] V(input logic [7:0] d, input logic [1:0] m,
                                      input logic [1:0] c, input logic [2:0] f);
        return {d, m, c, f};
    endfunction

    function automatic ent_t E(input logic s, input logic [4:0] b, input int x, input logic [14:0] v);
        return '{setm: s, btn: b, extra: 8'(x), v: v, chk_w: 1'b0, w: 8'h00};
    endfunction

    function automatic ent_t EW(input logic s, input logic [4:0] b, input int x,
                                input logic [14:0] v, input logic [7:0] w);
        return '{setm: s, btn: b, extra: 8'(x), v: v, chk_w: 1'b1, w: w};
    endfunction

    // Drive one transaction from a negedge: pulse held for one edge, then 'extra' idle edges.
    task automatic apply(input ent_t e);
        set_mode = e.setm;
        btn      = e.btn;
        sb.push_back(e);
        @(negedge clk);
        btn = '0;
        repeat (int'(e.extra)) @(negedge clk);
    endtask

    task automatic test_reset();
        ent_t e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back(E(1'b0, 5'b0, 0, V(8'h00, 2'b01, 2'b01, 3'b000)));
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
            errors++;
            $display("FAIL reset: got %h want %h", obs, e.v);
        end
        $display("reset obs=%h", obs);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_set_edit();
        ent_t t[$];
        ent_t e;
        t.push_back(E(1, 5'b0,        0, V(8'h00, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_INC,       0, V(8'h01, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_INC,       0, V(8'h02, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_INC,       0, V(8'h03, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_SL,        0, V(8'h03, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_INC,       0, V(8'h13, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_SL | B_SR, 0, V(8'h13, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_SL,        0, V(8'h13, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_SR,        0, V(8'h13, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_SR,        0, V(8'h13, 2'b11, 2'b01, 3'b000)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL set_edit[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("set_edit[%0d] btn=%b obs=%h", k, e.btn, obs);
        end
    endtask

    task automatic test_saturate_wrap();
        ent_t t[$];
        ent_t e;
        for (int k = 1; k <= 3; k++)
            t.push_back(EW(1, B_DEC, 0, V(8'h13 - 8'(k), 2'b11, 2'b01, 3'b000), 8'h13 - 8'(k)));
        for (int k = 1; k <= 9; k++)
            t.push_back(EW(1, B_INC, 0, V(8'h10 + 8'(k), 2'b11, 2'b01, 3'b000), 8'h10 + 8'(k)));
        t.push_back(EW(1, B_INC,         0, V(8'h19, 2'b11, 2'b01, 3'b000), 8'h10));
        t.push_back(EW(1, B_DEC,         0, V(8'h18, 2'b11, 2'b01, 3'b000), 8'h19));
        t.push_back(EW(1, B_INC | B_DEC, 0, V(8'h18, 2'b11, 2'b01, 3'b000), 8'h19));
        for (int k = 1; k <= 9; k++)
            t.push_back(EW(1, B_DEC, 0, V((k <= 8) ? 8'h18 - 8'(k) : 8'h10, 2'b11, 2'b01, 3'b000),
                           8'h19 - 8'(k)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL sat[%0d]: got %h want %h", k, obs, e.v);
            end
            checks++;
            if (w_digits !== e.w) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h want %h", k, w_digits, e.w);
            end
            $display("sat_wrap[%0d] btn=%b sat=%h wrap=%h", k, e.btn, digits, w_digits);
        end
    endtask

    task automatic test_borrow();
        ent_t t[$];
        ent_t e;
        t.push_back(E(0, 5'b0, 0,  V(8'h10, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST, 0,  V(8'h10, 2'b11, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 2,  V(8'h10, 2'b11, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 0,  V(8'h09, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 34, V(8'h01, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 0,  V(8'h00, 2'b01, 2'b01, 3'b011)));
        t.push_back(E(0, 5'b0, 0,  V(8'h00, 2'b01, 2'b01, 3'b001)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL borrow[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("borrow[%0d] obs=%h", k, obs);
        end
    endtask

    task automatic test_done_and_idle();
        ent_t t[$];
        ent_t e;
        t.push_back(E(0, B_ST,  0, V(8'h10, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, 5'b0,  0, V(8'h10, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(1, B_SL,  0, V(8'h10, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_DEC, 0, V(8'h00, 2'b11, 2'b10, 3'b000)));
        t.push_back(E(1, B_SR,  0, V(8'h00, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0,  0, V(8'h00, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST,  0, V(8'h00, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0,  3, V(8'h00, 2'b01, 2'b01, 3'b000)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL done_idle[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("done_idle[%0d] obs=%h", k, obs);
        end
    endtask

    task automatic test_pause();
        ent_t t[$];
        ent_t e;
        t.push_back(E(1, 5'b0, 0, V(8'h00, 2'b11, 2'b01, 3'b000)));
        for (int k = 1; k <= 5; k++)
            t.push_back(E(1, B_INC, 0, V(8'(k), 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0, 0,  V(8'h05, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST, 0,  V(8'h05, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 3,  V(8'h04, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 0,  V(8'h04, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, B_ST, 0,  V(8'h04, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0, 19, V(8'h04, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST, 0,  V(8'h04, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 0,  V(8'h04, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 0,  V(8'h03, 2'b01, 2'b01, 3'b100)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL pause[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("pause[%0d] obs=%h", k, obs);
        end
    endtask

    task automatic test_priority();
        ent_t t[$];
        ent_t e;
        t.push_back(E(1, 5'b0, 0, V(8'h05, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0, 0, V(8'h05, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST, 0, V(8'h05, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(1, B_ST, 0, V(8'h05, 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0, 0, V(8'h05, 2'b01, 2'b01, 3'b000)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL priority[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("priority[%0d] obs=%h", k, obs);
        end
    endtask

    task automatic test_async_reset();
        ent_t t[$];
        ent_t e;
        t.push_back(E(1, 5'b0, 0, V(8'h05, 2'b11, 2'b01, 3'b000)));
        for (int k = 1; k <= 4; k++)
            t.push_back(E(1, B_DEC, 0, V(8'h05 - 8'(k), 2'b11, 2'b01, 3'b000)));
        t.push_back(E(0, 5'b0, 0, V(8'h01, 2'b01, 2'b01, 3'b000)));
        t.push_back(E(0, B_ST, 0, V(8'h01, 2'b01, 2'b01, 3'b100)));
        t.push_back(E(0, 5'b0, 1, V(8'h01, 2'b01, 2'b01, 3'b100)));
        for (int k = 0; k < t.size(); k++) begin
            apply(t[k]);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL arst_setup[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("arst_setup[%0d] obs=%h", k, obs);
        end
        // Assert reset between edges, one tick before the count would expire.
        #2 rst_n = 1'b0;
        sb.push_back(E(0, 5'b0, 0, V(8'h00, 2'b01, 2'b01, 3'b000)));
        #1;
        e = sb.pop_front();
        checks++;
        if (obs !== e.v) begin
            errors++;
            $display("FAIL arst_immediate: got %h want %h", obs, e.v);
        end
        $display("arst_immediate obs=%h", obs);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sb.push_back(E(0, 5'b0, 0, V(8'h00, 2'b01, 2'b01, 3'b000)));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL arst_after[%0d]: got %h want %h", k, obs, e.v);
            end
            $display("arst_after[%0d] obs=%h", k, obs);
        end
    endtask

    initial begin
        test_reset();
        test_set_edit();
        test_saturate_wrap();
        test_borrow();
        test_done_and_idle();
        test_pause();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
